// File: rtl/queue_table_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : queue_table_arbiter_pkg
// Description : Shared types for the queue-table BRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package queue_table_arbiter_pkg;

    // Requester that issued a BRAM read, carried alongside the read pipeline
    typedef enum logic {
        OWNER_DP  = 1'b0,
        OWNER_CFG = 1'b1
    } q_table_owner_t;

    typedef enum logic [1:0] {
        CFG_IDLE    = 2'd0,
        CFG_RD_WAIT = 2'd1,
        CFG_RESP    = 2'd2
    } cfg_state_t;

endpackage
`default_nettype wire

// File: rtl/q_table_rd_tracker.sv
`default_nettype none
// ============================================================================
// Module      : q_table_rd_tracker
// Description : RD_LATENCY-deep {valid, owner} shift register that tags each
//               BRAM read so its data can be routed back to the issuer.
// Revision    : 1.0 - initial release
// ============================================================================
module q_table_rd_tracker
    import queue_table_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_valid,
    input  q_table_owner_t i_owner,
    output logic           o_valid,
    output q_table_owner_t o_owner
);

    logic [RD_LATENCY-1:0] r_valid;
    logic [RD_LATENCY-1:0] r_owner;

    generate
        if (RD_LATENCY == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= '0;
                    r_owner <= '0;
                end else begin
                    r_valid <= i_valid;
                    r_owner <= i_owner;
                end
            end
        end else begin : g_shift
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= '0;
                    r_owner <= '0;
                end else begin
                    r_valid <= {r_valid[RD_LATENCY-2:0], i_valid};
                    r_owner <= {r_owner[RD_LATENCY-2:0], i_owner};
                end
            end
        end
    endgenerate

    assign o_valid = r_valid[RD_LATENCY-1];
    assign o_owner = q_table_owner_t'(r_owner[RD_LATENCY-1]);

endmodule
`default_nettype wire

// File: rtl/queue_table_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : queue_table_arbiter
// Description : Shares one single-port queue-table BRAM between the datapath
//               (priority) and MMIO config (anti-starvation guaranteed).
// Revision    : 1.0 - initial release
// ============================================================================
module queue_table_arbiter
    import queue_table_arbiter_pkg::*;
#(
    parameter int NB_QUEUES  = 8192,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 2,
    parameter int MAX_STARVE = 16,
    localparam int AW = $clog2(NB_QUEUES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dp_rd,
    input  logic                  dp_wr,
    input  logic [AW-1:0]         dp_addr,
    input  logic [DATA_WIDTH-1:0] dp_wr_data,
    output logic                  dp_gnt,
    output logic                  dp_rd_valid,
    output logic [DATA_WIDTH-1:0] dp_rd_data,
    input  logic                  cfg_req_valid,
    output logic                  cfg_req_ready,
    input  logic                  cfg_req_wr,
    input  logic [AW-1:0]         cfg_req_addr,
    input  logic [DATA_WIDTH-1:0] cfg_req_data,
    output logic                  cfg_resp_valid,
    input  logic                  cfg_resp_ready,
    output logic [DATA_WIDTH-1:0] cfg_resp_data,
    output logic [AW-1:0]         bram_addr,
    output logic                  bram_rd_en,
    output logic                  bram_wr_en,
    output logic [DATA_WIDTH-1:0] bram_wr_data,
    input  logic [DATA_WIDTH-1:0] bram_rd_data,
    output logic [31:0]           cfg_stall_cnt
);

    localparam int c_starve_w = $clog2(MAX_STARVE + 1);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(MAX_STARVE);

    cfg_state_t              r_state;
    cfg_state_t              w_state_nxt;
    logic [c_starve_w-1:0]   r_starve;
    logic [31:0]             r_stall;
    logic [DATA_WIDTH-1:0]   r_resp_data;

    logic                    w_dp_req;
    logic                    w_cfg_elig;
    logic                    w_force;
    logic                    w_dp_gnt;
    logic                    w_cfg_gnt;
    logic                    w_capture;
    logic                    w_trk_valid;
    q_table_owner_t          w_trk_owner;
    logic                    w_dp_ret;
    logic                    w_cfg_ret;

    // Grants are suppressed while rst is high so every output reads 0 in reset
    assign w_dp_req   = dp_rd | dp_wr;
    assign w_cfg_elig = !rst && cfg_req_valid && (r_state == CFG_IDLE);
    assign w_force    = w_cfg_elig && (r_starve == c_starve_max);
    assign w_dp_gnt   = !rst && w_dp_req && !w_force;
    assign w_cfg_gnt  = w_cfg_elig && (w_force || !w_dp_req);

    assign dp_gnt        = w_dp_gnt;
    assign cfg_req_ready = w_cfg_gnt;
    assign cfg_stall_cnt = r_stall;

    always_comb begin
        bram_addr    = '0;
        bram_rd_en   = 1'b0;
        bram_wr_en   = 1'b0;
        bram_wr_data = '0;
        if (w_cfg_gnt) begin
            bram_addr    = cfg_req_addr;
            bram_rd_en   = !cfg_req_wr;
            bram_wr_en   = cfg_req_wr;
            bram_wr_data = cfg_req_data;
        end else if (w_dp_gnt) begin
            bram_addr    = dp_addr;
            bram_rd_en   = dp_rd;
            bram_wr_en   = dp_wr;
            bram_wr_data = dp_wr_data;
        end
    end

    q_table_rd_tracker #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_tracker (
        .clk     (clk),
        .rst     (rst),
        .i_valid (bram_rd_en),
        .i_owner (w_cfg_gnt ? OWNER_CFG : OWNER_DP),
        .o_valid (w_trk_valid),
        .o_owner (w_trk_owner)
    );

    assign w_dp_ret    = !rst && w_trk_valid && (w_trk_owner == OWNER_DP);
    assign w_cfg_ret   = !rst && w_trk_valid && (w_trk_owner == OWNER_CFG);
    assign dp_rd_valid = w_dp_ret;
    assign dp_rd_data  = w_dp_ret ? bram_rd_data : '0;

    // The response is presented the cycle the data leaves the pipeline;
    // the captured copy keeps it stable while cfg_resp_ready is low.
    always_comb begin
        w_state_nxt    = r_state;
        w_capture      = 1'b0;
        cfg_resp_valid = 1'b0;
        cfg_resp_data  = '0;
        if (!rst) begin
            case (r_state)
                CFG_IDLE: begin
                    if (w_cfg_gnt && !cfg_req_wr) w_state_nxt = CFG_RD_WAIT;
                end
                CFG_RD_WAIT: begin
                    if (w_cfg_ret) begin
                        w_capture      = 1'b1;
                        cfg_resp_valid = 1'b1;
                        cfg_resp_data  = bram_rd_data;
                        w_state_nxt    = cfg_resp_ready ? CFG_IDLE : CFG_RESP;
                    end
                end
                CFG_RESP: begin
                    cfg_resp_valid = 1'b1;
                    cfg_resp_data  = r_resp_data;
                    if (cfg_resp_ready) w_state_nxt = CFG_IDLE;
                end
                default: w_state_nxt = CFG_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CFG_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve    <= '0;
            r_stall     <= '0;
            r_resp_data <= '0;
        end else begin
            if (w_cfg_gnt) begin
                r_starve <= '0;
            end else if (w_cfg_elig) begin
                if (r_starve != c_starve_max) r_starve <= r_starve + c_starve_w'(1);
                r_stall <= r_stall + 32'd1;
            end
            if (w_capture) r_resp_data <= bram_rd_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_queue_table_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_queue_table_arbiter
// Description : Randomized + directed scoreboard bench for queue_table_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_queue_table_arbiter;

    localparam int NB = 8192;
    localparam int DW = 32;
    localparam int L  = 2;
    localparam int MS = 16;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          dp_rd, dp_wr;
    logic [AW-1:0] dp_addr;
    logic [DW-1:0] dp_wr_data;
    logic          dp_gnt, dp_rd_valid;
    logic [DW-1:0] dp_rd_data;
    logic          cfg_req_valid, cfg_req_ready, cfg_req_wr;
    logic [AW-1:0] cfg_req_addr;
    logic [DW-1:0] cfg_req_data;
    logic          cfg_resp_valid, cfg_resp_ready;
    logic [DW-1:0] cfg_resp_data;
    logic [AW-1:0] bram_addr;
    logic          bram_rd_en, bram_wr_en;
    logic [DW-1:0] bram_wr_data, bram_rd_data;
    logic [31:0]   cfg_stall_cnt;

    queue_table_arbiter #(
        .NB_QUEUES (NB), .DATA_WIDTH (DW), .RD_LATENCY (L), .MAX_STARVE (MS)
    ) dut (
        .clk (clk), .rst (rst),
        .dp_rd (dp_rd), .dp_wr (dp_wr), .dp_addr (dp_addr), .dp_wr_data (dp_wr_data),
        .dp_gnt (dp_gnt), .dp_rd_valid (dp_rd_valid), .dp_rd_data (dp_rd_data),
        .cfg_req_valid (cfg_req_valid), .cfg_req_ready (cfg_req_ready),
        .cfg_req_wr (cfg_req_wr), .cfg_req_addr (cfg_req_addr), .cfg_req_data (cfg_req_data),
        .cfg_resp_valid (cfg_resp_valid), .cfg_resp_ready (cfg_resp_ready),
        .cfg_resp_data (cfg_resp_data),
        .bram_addr (bram_addr), .bram_rd_en (bram_rd_en), .bram_wr_en (bram_wr_en),
        .bram_wr_data (bram_wr_data), .bram_rd_data (bram_rd_data),
        .cfg_stall_cnt (cfg_stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_val(input int a);
        return (a == 5) ? 32'hDEADBEEF : (32'h5A000000 ^ 32'(a * 32'h00010003));
    endfunction

    // BRAM: write-first, registered, RD_LATENCY cycles from rd_en to data
    logic [31:0] mem [int];
    logic [31:0] rd_pipe [L];
    always @(posedge clk) begin
        if (bram_wr_en) mem[int'(bram_addr)] = bram_wr_data;
        rd_pipe[0] <= !bram_rd_en ? 32'h0 :
                      (mem.exists(int'(bram_addr)) ? mem[int'(bram_addr)] : init_val(int'(bram_addr)));
        for (int i = L - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_rd_data = rd_pipe[L-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: table contents and expected response timing
    typedef struct { logic [31:0] data; int due; } dp_exp_t;
    dp_exp_t     dp_q [$];
    logic [31:0] cfg_q [$];
    logic [31:0] shadow [int];
    int          m_starve = 0;
    logic [31:0] m_stall  = 0;
    logic        m_busy   = 0;
    int          m_due    = 0;
    logic        g_dp     = 0;
    logic        g_cfg    = 0;

    function automatic logic [31:0] shadow_rd(input int a);
        return shadow.exists(a) ? shadow[a] : init_val(a);
    endfunction

    always @(negedge clk) begin : p_model
        logic elig, frc, req, e_dp, e_cfg, e_rd, e_wr, e_resp;
        if (rst) begin
            chk("rst_dp_gnt", dp_gnt, 0);
            chk("rst_cfg_req_ready", cfg_req_ready, 0);
            chk("rst_bram_rd_en", bram_rd_en, 0);
            chk("rst_bram_wr_en", bram_wr_en, 0);
            chk("rst_dp_rd_valid", dp_rd_valid, 0);
            chk("rst_cfg_resp_valid", cfg_resp_valid, 0);
            m_starve = 0; m_stall = 0; m_busy = 0;
            dp_q.delete(); cfg_q.delete();
            g_dp = 0; g_cfg = 0;
        end else begin
            if (dp_rd && dp_wr) $error("dp_rd and dp_wr asserted together");
            req   = dp_rd || dp_wr;
            elig  = cfg_req_valid && !m_busy;
            frc   = elig && (m_starve == MS);
            e_dp  = req && !frc;
            e_cfg = elig && (frc || !req);
            chk("dp_gnt", dp_gnt, e_dp);
            chk("cfg_req_ready", cfg_req_ready, e_cfg);
            e_rd = (e_cfg && !cfg_req_wr) || (e_dp && dp_rd);
            e_wr = (e_cfg && cfg_req_wr) || (e_dp && dp_wr);
            chk("bram_rd_en", bram_rd_en, e_rd);
            chk("bram_wr_en", bram_wr_en, e_wr);
            if (e_rd || e_wr) chk("bram_addr", bram_addr, e_cfg ? cfg_req_addr : dp_addr);
            if (e_wr) chk("bram_wr_data", bram_wr_data, e_cfg ? cfg_req_data : dp_wr_data);
            chk("cfg_stall_cnt", cfg_stall_cnt, m_stall);
            e_resp = m_busy && (cyc >= m_due);
            chk("cfg_resp_valid", cfg_resp_valid, e_resp);
            if (e_resp && cfg_resp_ready) m_busy = 0;
            if (e_cfg) begin
                m_starve = 0;
                if (cfg_req_wr) shadow[int'(cfg_req_addr)] = cfg_req_data;
                else begin
                    cfg_q.push_back(shadow_rd(int'(cfg_req_addr)));
                    m_busy = 1;
                    m_due  = cyc + L;
                end
            end else if (elig) begin
                if (m_starve < MS) m_starve++;
                m_stall = m_stall + 1;
            end
            if (e_dp) begin
                if (dp_wr) shadow[int'(dp_addr)] = dp_wr_data;
                else dp_q.push_back('{data: shadow_rd(int'(dp_addr)), due: cyc + L});
            end
            g_dp  = e_dp;
            g_cfg = e_cfg;
        end
    end

    // Monitor: pops expectations whenever the DUT presents read data
    always @(negedge clk) begin : p_monitor
        dp_exp_t e;
        if (!rst) begin
            if (dp_rd_valid) begin
                if (dp_q.size() == 0) chk("dp_rd_valid_unexpected", 1, 0);
                else begin
                    e = dp_q.pop_front();
                    chk("dp_rd_data", dp_rd_data, e.data);
                    chk("dp_rd_cycle", cyc, e.due);
                end
            end else if (dp_q.size() > 0 && dp_q[0].due <= cyc) begin
                chk("dp_rd_valid_missing", 0, 1);
                void'(dp_q.pop_front());
            end
            if (cfg_resp_valid) begin
                if (cfg_q.size() == 0) chk("cfg_resp_unexpected", 1, 0);
                else begin
                    chk("cfg_resp_data", cfg_resp_data, cfg_q[0]);
                    if (cfg_resp_ready) void'(cfg_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; dp_rd = 0; dp_wr = 0; cfg_req_valid = 0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic dp_op(input logic wr, input int a, input logic [31:0] d);
        int n = 0;
        dp_rd = !wr; dp_wr = wr; dp_addr = AW'(a); dp_wr_data = d;
        do begin tick(); n++; end while (!g_dp && n < 200);
        if (!g_dp) chk("dp_gnt_timeout", 0, 1);
        dp_rd = 0; dp_wr = 0;
    endtask

    task automatic cfg_op(input logic wr, input int a, input logic [31:0] d, output int n);
        n = 0;
        cfg_req_valid = 1; cfg_req_wr = wr; cfg_req_addr = AW'(a); cfg_req_data = d;
        do begin tick(); n++; end while (!g_cfg && n < 200);
        if (!g_cfg) chk("cfg_gnt_timeout", 0, 1);
        cfg_req_valid = 0;
    endtask

    initial begin : p_stim
        int n;
        rst = 1; dp_rd = 0; dp_wr = 0; dp_addr = '0; dp_wr_data = '0;
        cfg_req_valid = 0; cfg_req_wr = 0; cfg_req_addr = '0; cfg_req_data = '0;
        cfg_resp_ready = 0;
        do_reset();
        chk("reset_stall_cnt", cfg_stall_cnt, 0);

        // Back-to-back datapath reads
        for (int i = 0; i < 8; i++) dp_op(0, i, 0);
        repeat (4) tick();

        // Config read held under backpressure, second request waits
        cfg_op(0, 5, 0, n);
        cfg_req_valid = 1; cfg_req_wr = 0; cfg_req_addr = AW'(6);
        repeat (5) begin
            tick();
            chk("cfg_ready_while_busy", cfg_req_ready, 0);
        end
        chk("cfg5_resp_data", cfg_resp_data, 32'hDEADBEEF);
        chk("cfg5_resp_valid", cfg_resp_valid, 1);
        cfg_resp_ready = 1;
        tick();
        cfg_resp_ready = 0;
        cfg_op(0, 6, 0, n);
        chk("cfg_regrant_after_hs", n, 1);
        cfg_resp_ready = 1;
        repeat (4) tick();

        // Starvation bound under continuous datapath reads
        do_reset();
        cfg_req_valid = 1; cfg_req_wr = 0; cfg_req_addr = AW'(7);
        dp_rd = 1; dp_addr = '0;
        n = 0;
        do begin
            tick(); n++;
            dp_addr = dp_addr + AW'(1);
        end while (!g_cfg && n < 40);
        chk("starve_gnt_cycle", n, MS + 1);
        chk("starve_stall_cnt", cfg_stall_cnt, MS);
        cfg_req_valid = 0;
        tick();
        dp_rd = 0;
        repeat (4) tick();

        // Config write then immediate datapath read of the same entry
        cfg_op(1, 3, 32'h1234, n);
        dp_op(0, 3, 0);
        repeat (3) tick();

        // Config read in flight between datapath reads
        cfg_op(0, 12, 0, n);
        dp_op(0, 12, 0); dp_op(0, 13, 0); dp_op(0, 14, 0);
        repeat (4) tick();

        // Reset with a config read in flight
        cfg_op(0, 9, 0, n);
        rst = 1;
        tick();
        rst = 0;
        cfg_op(0, 10, 0, n);
        chk("post_rst_cfg_gnt", n, 1);
        repeat (4) tick();

        // Random mixed traffic on a small address window
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (g_dp) begin dp_rd = 0; dp_wr = 0; end
            if (g_cfg) cfg_req_valid = 0;
            if (!dp_rd && !dp_wr && $urandom_range(99) < ((c < 1500) ? 50 : 95)) begin
                if ($urandom_range(3) == 0) dp_wr = 1; else dp_rd = 1;
                dp_addr = AW'($urandom_range(15));
                dp_wr_data = $urandom;
            end
            if (!cfg_req_valid && $urandom_range(9) == 0) begin
                cfg_req_valid = 1;
                cfg_req_wr = ($urandom_range(2) == 0);
                cfg_req_addr = AW'($urandom_range(15));
                cfg_req_data = $urandom;
            end
            cfg_resp_ready = ($urandom_range(1) == 1);
        end

        // Drain
        cfg_resp_ready = 1;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (g_dp) begin dp_rd = 0; dp_wr = 0; end
            if (g_cfg) cfg_req_valid = 0;
        end
        chk("dp_q_drained", dp_q.size(), 0);
        chk("cfg_q_drained", cfg_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : p_watchdog
        #1000000;
        bad++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
